cfg_chain_loader: RTL

//  Parametrised loader for the fabric configuration scan chain(s), replacing hand-driven prog_in/prog_clk/prog_en.

---
 rtl/cfg_chain_loader_if.sv | 26 ++
 rtl/cfg_chain_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader_if.sv
// rtl/cfg_chain_loader_if.sv - bitstream word stream and readback word strobe for the chain loader
interface cfg_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  rb_data,
    input  rb_valid
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output rb_data,
    output rb_valid
  );
endinterface

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serialises bitstream words onto parallel config scan chains and returns old contents
module cfg_chain_loader #(
  parameter int CHAIN_LEN  = 1480,
  parameter int NUM_CHAINS = 1,
  parameter int WORD_W     = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  cfg_chain_loader_if.slave     bus,
  output logic [NUM_CHAINS-1:0] prog_in,
  output logic                  prog_clk,
  output logic                  prog_en,
  input  logic [NUM_CHAINS-1:0] prog_out,
  output logic                  busy,
  output logic                  done
);
  localparam int SPW    = WORD_W / NUM_CHAINS;
  localparam int SUB_W  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STEP_W = $clog2(CHAIN_LEN + 1);

  localparam logic [SUB_W-1:0]  LAST_SUB  = SUB_W'(SPW - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(CLK_DIV - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, FINISH} state_t;

  state_t                state_q, state_d;
  logic [WORD_W-1:0]     word_q;
  logic [SUB_W-1:0]      sub_q;
  logic [DIV_W-1:0]      div_q;
  logic [STEP_W-1:0]     step_q;
  logic [NUM_CHAINS-1:0] prog_in_q;
  logic [WORD_W-1:0]     rb_acc_q;
  logic [WORD_W-1:0]     rb_data_q;
  logic                  rb_valid_q;

  logic div_end, word_end, step_last, take;

  assign div_end   = (div_q == LAST_DIV);
  assign word_end  = (sub_q == LAST_SUB);
  assign step_last = (step_q == LAST_STEP);
  assign take      = (state_q == FETCH) && bus.s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (bus.s_valid) state_d = LOW;
      LOW:     if (div_end) state_d = HIGH;
      HIGH: begin
        if (div_end) begin
          if (step_last)     state_d = FINISH;
          else if (word_end) state_d = FETCH;
          else               state_d = LOW;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // word_q is a shift register: the slice for the next step always sits in its low bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      sub_q      <= '0;
      div_q      <= '0;
      step_q     <= '0;
      prog_in_q  <= '0;
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            step_q   <= '0;
            sub_q    <= '0;
            div_q    <= '0;
            rb_acc_q <= '0;
          end
        end
        FETCH: begin
          if (take) begin
            prog_in_q <= bus.s_data[NUM_CHAINS-1:0];
            word_q    <= bus.s_data >> NUM_CHAINS;
            sub_q     <= '0;
            div_q     <= '0;
          end
        end
        LOW: begin
          if (div_end) begin
            div_q <= '0;
            // pre-shift chain outputs, sampled on the edge where prog_clk rises
            for (int s = 0; s < SPW; s++) begin
              if (sub_q == SUB_W'(s)) rb_acc_q[s*NUM_CHAINS +: NUM_CHAINS] <= prog_out;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        HIGH: begin
          if (div_end) begin
            div_q  <= '0;
            step_q <= step_q + 1'b1;
            if (step_last || word_end) begin
              rb_data_q  <= rb_acc_q;
              rb_valid_q <= 1'b1;
              rb_acc_q   <= '0;
            end else begin
              sub_q     <= sub_q + 1'b1;
              prog_in_q <= word_q[NUM_CHAINS-1:0];
              word_q    <= word_q >> NUM_CHAINS;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready  = (state_q == FETCH);
  assign bus.rb_data  = rb_data_q;
  assign bus.rb_valid = rb_valid_q;
  assign prog_in      = prog_in_q;
  assign prog_clk     = (state_q == HIGH);
  assign prog_en      = (state_q == FETCH) || (state_q == LOW) || (state_q == HIGH);
  assign busy         = prog_en;
  assign done         = (state_q == FINISH);
endmodule
